// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ byte producers.
// Handles launch handshake, busy tracking, inter-frame gap and burst hold.
module uart_tx_sched #(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = 8,
    parameter int MAX_BURST    = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_last,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        grant,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_busy,
    output logic                    timeout_err
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
    localparam logic [7:0] GAP_LAST =
        (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
    localparam logic [15:0] TO_LAST = 16'(BUSY_TIMEOUT - 1);
    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   pick_idx;
    logic            pick_ok;
    logic [3:0]      bcnt;
    logic            last_q;
    logic [7:0]      gcnt;
    logic [15:0]     tcnt;
    logic            owner_req;
    logic            cont;

    // Search ptr+1, ptr+2, ... with wrap; the nearest set bit wins.
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % N_REQ]) begin
                pick_ok  = 1'b1;
                pick_idx = IW'((int'(ptr) + k) % N_REQ);
            end
        end
    end

    assign owner_req = req[owner];
    assign cont      = owner_req && !last_q && (bcnt < BURST_MAX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= IW'(N_REQ - 1);
            owner       <= '0;
            bcnt        <= '0;
            last_q      <= 1'b0;
            gcnt        <= '0;
            tcnt        <= '0;
            ack         <= '0;
            grant       <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            timeout_err <= 1'b0;
        end else begin
            ack      <= '0;
            tx_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_ok) begin
                        grant <= ONE << pick_idx;
                        owner <= pick_idx;
                        bcnt  <= '0;
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (!owner_req) begin
                        grant <= '0;
                        ptr   <= owner;
                        state <= IDLE;
                    end else if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= req_data[owner*DATA_W +: DATA_W];
                        ack      <= grant;
                        bcnt     <= bcnt + 4'd1;
                        last_q   <= req_last[owner];
                        tcnt     <= '0;
                        state    <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (tcnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        gcnt        <= '0;
                        state       <= GAP;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        gcnt  <= '0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (gcnt == GAP_LAST) begin
                        if (cont) begin
                            state <= LAUNCH;
                        end else begin
                            grant <= '0;
                            ptr   <= owner;
                            state <= IDLE;
                        end
                    end else begin
                        gcnt <= gcnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a simple transmitter model.
// Requesters are modelled as per-index pending byte counters.
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        timeout_err;

    uart_tx_sched dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_last(req_last),
        .req_data(req_data),
        .ack(ack),
        .grant(grant),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_busy(tx_busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // transmitter model: busy rises dly cycles after tx_start, lasts len
    bit   tie0 = 1'b0;
    bit   force_busy = 1'b0;
    int   dly = 2;
    int   len = 6;
    int   mphase = 0;
    int   mcnt = 0;
    logic busy_m = 1'b0;

    assign tx_busy = busy_m | force_busy;

    always @(posedge clk) begin
        if (!reset) begin
            mphase <= 0;
            busy_m <= 1'b0;
        end else if (tx_start && !tie0) begin
            mphase <= 1;
            mcnt   <= dly;
        end else if (mphase == 1) begin
            if (mcnt <= 1) begin
                mphase <= 2;
                busy_m <= 1'b1;
                mcnt   <= len;
            end else begin
                mcnt <= mcnt - 1;
            end
        end else if (mphase == 2) begin
            if (mcnt <= 1) begin
                mphase <= 0;
                busy_m <= 1'b0;
            end else begin
                mcnt <= mcnt - 1;
            end
        end
    end

    int       n_chk = 0;
    int       n_fail = 0;
    int       cyc = 0;
    int       fall_cyc = 0;
    bit       fall_v = 1'b0;
    logic     prev_bm = 1'b0;
    int       pend[4];
    logic [7:0] dat[4];
    bit       lst[4];
    bit       incr[4];
    int       log_own[$];
    int       log_dat[$];
    int       log_cyc[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req[i]          = (pend[i] != 0);
            req_last[i]     = lst[i];
            req_data[i*8+:8] = dat[i];
        end
    endtask

    task automatic tick();
        int own;
        @(negedge clk);
        cyc++;
        if (prev_bm && !busy_m) begin
            fall_cyc = cyc;
            fall_v   = 1'b1;
        end
        prev_bm = busy_m;
        if (tx_start || ack != 4'd0) begin
            chk("ack_grant", 32'(ack), 32'(grant));
            chk("ack_start", 32'(tx_start), 32'd1);
            own = 0;
            for (int i = 0; i < 4; i++) begin
                if (ack[i]) begin
                    own = i;
                    if (pend[i] > 0) pend[i]--;
                    if (incr[i]) dat[i] = dat[i] + 8'd1;
                end
            end
            log_own.push_back(own);
            log_dat.push_back(int'(tx_data));
            log_cyc.push_back(cyc);
            if (fall_v) chk("gap", 32'((cyc - fall_cyc) >= 4), 32'd1);
            fall_v = 1'b0;
        end
        drive();
    endtask

    function automatic bit pend_any();
        return (pend[0] | pend[1] | pend[2] | pend[3]) != 0;
    endfunction

    task automatic settle(input int lim);
        int n = 0;
        while ((pend_any() || grant != 4'd0) && n < lim) begin
            tick();
            n++;
        end
        if (n >= lim) chk("settle", 32'd0, 32'd1);
    endtask

    task automatic clr_req();
        for (int i = 0; i < 4; i++) begin
            pend[i] = 0;
            lst[i]  = 1'b1;
            incr[i] = 1'b0;
            dat[i]  = 8'h00;
        end
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clr_req();
        repeat (3) tick();
        reset = 1'b1;
        tick();
        log_own.delete();
        log_dat.delete();
        log_cyc.delete();
        fall_v = 1'b0;
    endtask

    task automatic chk_order(input string tag, input int own[],
                             input int dv[]);
        chk({tag, "_cnt"}, 32'(log_own.size()), 32'(own.size()));
        for (int i = 0; i < own.size(); i++) begin
            if (i < log_own.size()) begin
                chk({tag, "_own"}, 32'(log_own[i]), 32'(own[i]));
                chk({tag, "_dat"}, 32'(log_dat[i]), 32'(dv[i]));
            end
        end
    endtask

    initial begin
        int s;
        int n;
        reset = 1'b0;
        clr_req();
        do_reset();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_start", 32'(tx_start), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_to", 32'(timeout_err), 32'd0);

        // single requester, exact latency
        dly = 10;
        len = 6;
        pend[0] = 1;
        dat[0]  = 8'hA5;
        drive();
        tick();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_start0", 32'(tx_start), 32'd0);
        tick();
        chk("t1_start", 32'(tx_start), 32'd1);
        chk("t1_ack", 32'(ack), 32'h1);
        chk("t1_data", 32'(tx_data), 32'hA5);
        n = 0;
        while (grant != 4'd0 && n < 80) begin
            tick();
            n++;
        end
        chk("t1_rel", 32'(cyc - fall_cyc), 32'd3);
        repeat (4) tick();
        chk("t1_count", 32'(log_own.size()), 32'd1);

        // all four at once
        do_reset();
        dly = 2;
        len = 5;
        for (int i = 0; i < 4; i++) begin
            pend[i] = 1;
            dat[i]  = 8'(8'h11 * (i + 1));
        end
        drive();
        settle(300);
        chk_order("t2", '{0, 1, 2, 3}, '{8'h11, 8'h22, 8'h33, 8'h44});

        // burst cap
        do_reset();
        pend[0] = 5;
        lst[0]  = 1'b0;
        incr[0] = 1'b1;
        dat[0]  = 8'h50;
        pend[1] = 1;
        dat[1]  = 8'h61;
        drive();
        settle(400);
        chk_order("t3", '{0, 0, 0, 0, 1, 0},
                  '{8'h50, 8'h51, 8'h52, 8'h53, 8'h61, 8'h54});

        // transmitter busy when launch is reached
        do_reset();
        force_busy = 1'b1;
        pend[2] = 1;
        dat[2]  = 8'h3C;
        drive();
        repeat (8) tick();
        chk("t4_grant", 32'(grant), 32'h4);
        chk("t4_nolaunch", 32'(log_own.size()), 32'd0);
        force_busy = 1'b0;
        settle(100);
        chk_order("t4", '{2}, '{8'h3C});

        // busy never rises
        do_reset();
        tie0 = 1'b1;
        pend[1] = 1;
        dat[1]  = 8'h71;
        pend[3] = 1;
        dat[3]  = 8'h73;
        drive();
        n = 0;
        while (log_own.size() == 0 && n < 20) begin
            tick();
            n++;
        end
        s = (log_cyc.size() > 0) ? log_cyc[0] : cyc;
        n = 0;
        while (!timeout_err && n < 40) begin
            tick();
            n++;
        end
        chk("t5_lat", 32'(cyc - s), 32'd16);
        settle(200);
        chk_order("t5", '{1, 3}, '{8'h71, 8'h73});
        chk("t5_sticky", 32'(timeout_err), 32'd1);
        tie0 = 1'b0;

        // reset in the middle of a frame
        do_reset();
        dly = 1;
        len = 30;
        pend[0] = 1;
        dat[0]  = 8'h9E;
        drive();
        n = 0;
        while (!busy_m && n < 20) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk("t6_inframe", 32'(grant), 32'h1);
        reset = 1'b0;
        clr_req();
        tick();
        chk("t6_grant", 32'(grant), 32'd0);
        chk("t6_ack", 32'(ack), 32'd0);
        chk("t6_start", 32'(tx_start), 32'd0);
        chk("t6_data", 32'(tx_data), 32'd0);
        chk("t6_to", 32'(timeout_err), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        log_own.delete();
        log_dat.delete();
        log_cyc.delete();
        fall_v = 1'b0;
        dly = 2;
        len = 4;
        pend[2] = 1;
        dat[2]  = 8'h5A;
        drive();
        settle(100);
        chk_order("t6a", '{2}, '{8'h5A});
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pend[i] = 1;
            dat[i]  = 8'(8'hC0 + i);
        end
        drive();
        settle(300);
        chk_order("t6b", '{0, 1, 2, 3}, '{8'hC0, 8'hC1, 8'hC2, 8'hC3});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
